// File: rtl/tl_pkg.sv
// -----------------------------------------------------------------------------
// tl_pkg
// Shared definitions for the traffic-light phase scheduler:
//   - 3-bit phase encoding (also driven out on the debug 'phase' port)
//   - default phase durations in clock cycles
//   - requester ID used to remember who was last granted the cross phase
// -----------------------------------------------------------------------------
package tl_pkg;

    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] tl_state_t;

    localparam tl_state_t S_R1G  = 3'd0;  // road-1 green
    localparam tl_state_t S_R1Y  = 3'd1;  // road-1 yellow
    localparam tl_state_t S_CLR1 = 3'd2;  // all red before cross phase
    localparam tl_state_t S_R2G  = 3'd3;  // road-2 green
    localparam tl_state_t S_R2Y  = 3'd4;  // road-2 yellow
    localparam tl_state_t S_PEDG = 3'd5;  // pedestrian walk
    localparam tl_state_t S_PEDY = 3'd6;  // pedestrian clearance
    localparam tl_state_t S_CLR2 = 3'd7;  // all red before road-1 green

    localparam int T_GREEN1_DEF = 20;
    localparam int T_GREEN2_DEF = 10;
    localparam int T_YELLOW_DEF = 3;
    localparam int T_PED_DEF    = 8;
    localparam int T_ALLRED_DEF = 1;

    typedef enum logic {
        REQ_ROAD2 = 1'b0,
        REQ_PED   = 1'b1
    } tl_req_e;

endpackage

// File: rtl/tl_phase_timer.sv
// -----------------------------------------------------------------------------
// tl_phase_timer
// Loadable CNT_W-bit down-counter used as the phase timer.
//   clk, rst_n : clock, synchronous active-low reset (count <= RST_VAL)
//   load       : load load_val this cycle (takes priority over hold)
//   load_val   : value to load (phase duration - 1)
//   hold       : freeze the count
//   count      : current count
//   done       : count == 0
// -----------------------------------------------------------------------------
module tl_phase_timer #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             hold,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_val;
        else if (!hold)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) count_q <= RST_VAL;
        else        count_q <= count_d;
    end

    assign count = count_q;
    assign done  = (count_q == '0);

endmodule

// File: rtl/tl_phase_scheduler.sv
// -----------------------------------------------------------------------------
// tl_phase_scheduler
// Sequences road-1, road-2 and pedestrian lamps through fixed-duration phases
// and arbitrates the shared cross phase between the road-2 car sensor and the
// pedestrian button.
//
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   car_req           : road-2 car sensor (level, not latched)
//   ped_req           : pedestrian button (latched into ped_pending)
//   ped_ack           : one-cycle pulse in the first cycle of the walk phase
//   R1G/R1Y/R1R       : road-1 lamps
//   R2G/R2Y/R2R       : road-2 lamps
//   FG/FY/FR          : pedestrian lamps
//   phase             : current state encoding (debug)
//
// Build option: TL_PED_EN enables the pedestrian phase, button latch, ped_ack
// and round-robin arbitration. Without it the pedestrian lamps stay red,
// ped_req is ignored and road 2 is served whenever car_req is seen.
// -----------------------------------------------------------------------------
module tl_phase_scheduler
    import tl_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int T_GREEN1 = T_GREEN1_DEF,
    parameter int T_GREEN2 = T_GREEN2_DEF,
    parameter int T_YELLOW = T_YELLOW_DEF,
    parameter int T_PED    = T_PED_DEF,
    parameter int T_ALLRED = T_ALLRED_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       car_req,
    input  logic       ped_req,
    output logic       ped_ack,
    output logic       R1G,
    output logic       R1Y,
    output logic       R1R,
    output logic       R2G,
    output logic       R2Y,
    output logic       R2R,
    output logic       FG,
    output logic       FY,
    output logic       FR,
    output logic [2:0] phase
);

    localparam logic [CNT_W-1:0] D_GREEN1 = CNT_W'(T_GREEN1 - 1);
    localparam logic [CNT_W-1:0] D_GREEN2 = CNT_W'(T_GREEN2 - 1);
    localparam logic [CNT_W-1:0] D_YELLOW = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] D_PED    = CNT_W'(T_PED - 1);
    localparam logic [CNT_W-1:0] D_ALLRED = CNT_W'(T_ALLRED - 1);

    tl_state_t        state_q, state_d;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic [CNT_W-1:0] tmr_count;
    logic             tmr_done;

`ifdef TL_PED_EN
    logic    ped_pending_q, ped_pending_d;
    logic    ped_ack_q, ped_ack_d;
    tl_req_e last_served_q, last_served_d;
    logic    ped_entry;
`else
    logic    ped_req_unused;
    assign ped_req_unused = ped_req;
`endif

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
`ifdef TL_PED_EN
        last_served_d = last_served_q;
`endif
        case (state_q)
            S_R1G: begin
`ifdef TL_PED_EN
                if (tmr_done && (car_req || ped_pending_q)) begin
                    state_d = S_R1Y;
                    // Tie goes to whoever was not served last; last_served
                    // doubles as the grant consumed in S_CLR1.
                    if (car_req && ped_pending_q)
                        last_served_d = (last_served_q == REQ_ROAD2) ? REQ_PED : REQ_ROAD2;
                    else if (ped_pending_q)
                        last_served_d = REQ_PED;
                    else
                        last_served_d = REQ_ROAD2;
                end
`else
                if (tmr_done && car_req)
                    state_d = S_R1Y;
`endif
            end
            S_R1Y:  if (tmr_done) state_d = S_CLR1;
            S_CLR1: begin
`ifdef TL_PED_EN
                if (tmr_done)
                    state_d = (last_served_q == REQ_PED) ? S_PEDG : S_R2G;
`else
                if (tmr_done)
                    state_d = S_R2G;
`endif
            end
            S_R2G:  if (tmr_done) state_d = S_R2Y;
            S_R2Y:  if (tmr_done) state_d = S_CLR2;
`ifdef TL_PED_EN
            S_PEDG: if (tmr_done) state_d = S_PEDY;
            S_PEDY: if (tmr_done) state_d = S_CLR2;
`endif
            S_CLR2: if (tmr_done) state_d = S_R1G;
            default: state_d = S_R1G;
        endcase
    end

    // ---------------------------------------------------------------- phase timer
    // Reload on every state change; every transition changes state, so
    // "state_d != state_q" is exactly "entering a new phase".
    always_comb begin
        tmr_load     = (state_d != state_q);
        tmr_load_val = D_GREEN1;
        case (state_d)
            S_R1G:                 tmr_load_val = D_GREEN1;
            S_R2G:                 tmr_load_val = D_GREEN2;
            S_R1Y, S_R2Y, S_PEDY:  tmr_load_val = D_YELLOW;
            S_PEDG:                tmr_load_val = D_PED;
            S_CLR1, S_CLR2:        tmr_load_val = D_ALLRED;
            default:               tmr_load_val = D_GREEN1;
        endcase
    end

    // Holding at zero lets S_R1G wait indefinitely for a request.
    tl_phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (D_GREEN1)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .hold     (tmr_done),
        .count    (tmr_count),
        .done     (tmr_done)
    );

`ifdef TL_PED_EN
    // ---------------------------------------------------------------- ped latch
    // Clear beats set on the entry edge, so a press on that edge is served by
    // the walk that is starting; presses during walk/clearance re-arm it.
    assign ped_entry = (state_d == S_PEDG) && (state_q != S_PEDG);

    always_comb begin
        ped_pending_d = ped_pending_q | ped_req;
        if (ped_entry)
            ped_pending_d = 1'b0;
        ped_ack_d = ped_entry;
    end
`endif

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_R1G;
`ifdef TL_PED_EN
            ped_pending_q <= 1'b0;
            ped_ack_q     <= 1'b0;
            last_served_q <= REQ_PED;
`endif
        end else begin
            state_q       <= state_d;
`ifdef TL_PED_EN
            ped_pending_q <= ped_pending_d;
            ped_ack_q     <= ped_ack_d;
            last_served_q <= last_served_d;
`endif
        end
    end

    // ---------------------------------------------------------------- lamps
    assign R1G = (state_q == S_R1G);
    assign R1Y = (state_q == S_R1Y);
    assign R1R = ~(R1G | R1Y);
    assign R2G = (state_q == S_R2G);
    assign R2Y = (state_q == S_R2Y);
    assign R2R = ~(R2G | R2Y);
`ifdef TL_PED_EN
    assign FG      = (state_q == S_PEDG);
    assign FY      = (state_q == S_PEDY);
    assign FR      = ~(FG | FY);
    assign ped_ack = ped_ack_q;
`else
    assign FG      = 1'b0;
    assign FY      = 1'b0;
    assign FR      = 1'b1;
    assign ped_ack = 1'b0;
`endif

    assign phase = state_q;

endmodule

// File: tb/tb_tl_phase_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tl_phase_scheduler
// Directed scenarios followed by randomized car/button/reset traffic, checked
// every cycle against a phase-duration model (elapsed-time counter per phase),
// plus fixed-cycle checks of the documented timeline. Honours TL_PED_EN.
// -----------------------------------------------------------------------------
module tb_tl_phase_scheduler;
    import tl_pkg::*;

    localparam int T_GREEN1 = 20;
    localparam int T_GREEN2 = 10;
    localparam int T_YELLOW = 3;
    localparam int T_PED    = 8;
    localparam int T_ALLRED = 1;
`ifdef TL_PED_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       car_req = 1'b0;
    logic       ped_req = 1'b0;
    logic       ped_ack;
    logic       R1G, R1Y, R1R, R2G, R2Y, R2R, FG, FY, FR;
    logic [2:0] phase;

    tl_phase_scheduler #(
        .CNT_W(8), .T_GREEN1(T_GREEN1), .T_GREEN2(T_GREEN2),
        .T_YELLOW(T_YELLOW), .T_PED(T_PED), .T_ALLRED(T_ALLRED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .car_req(car_req), .ped_req(ped_req),
        .ped_ack(ped_ack),
        .R1G(R1G), .R1Y(R1Y), .R1R(R1R),
        .R2G(R2G), .R2Y(R2Y), .R2R(R2R),
        .FG(FG), .FY(FY), .FR(FR),
        .phase(phase)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;   // cycle index since reset release of the state now visible

    // Reference model: current phase, cycles already spent in it, button latch,
    // who got the last cross phase (1 = pedestrian), and the walk-entry pulse.
    tl_state_t m_cur  = S_R1G;
    int        m_t    = 0;
    bit        m_pend = 1'b0;
    bit        m_last = 1'b1;
    bit        m_ack  = 1'b0;

    function automatic int dur(input tl_state_t s);
        case (s)
            S_R1G:                return T_GREEN1;
            S_R2G:                return T_GREEN2;
            S_PEDG:               return T_PED;
            S_R1Y, S_R2Y, S_PEDY: return T_YELLOW;
            default:              return T_ALLRED;
        endcase
    endfunction

    // {R1G,R1Y,R1R, R2G,R2Y,R2R, FG,FY,FR}
    function automatic logic [8:0] lamps_of(input tl_state_t s);
        case (s)
            S_R1G:   return 9'b100_001_001;
            S_R1Y:   return 9'b010_001_001;
            S_R2G:   return 9'b001_100_001;
            S_R2Y:   return 9'b001_010_001;
            S_PEDG:  return 9'b001_001_100;
            S_PEDY:  return 9'b001_001_010;
            default: return 9'b001_001_001;
        endcase
    endfunction

    task automatic model_step(input bit c, input bit p, input bit r);
        tl_state_t nxt;
        bool_last: begin end
        if (!r) begin
            m_cur = S_R1G; m_t = 0; m_pend = 1'b0; m_last = 1'b1; m_ack = 1'b0;
            return;
        end
        nxt = m_cur;
        if (m_cur == S_R1G) begin
            if (m_t >= T_GREEN1 - 1 && (c || (PED && m_pend))) begin
                if (PED) begin
                    if (c && m_pend) m_last = ~m_last;
                    else             m_last = m_pend;
                end
                nxt = S_R1Y;
            end
        end else if (m_t == dur(m_cur) - 1) begin
            case (m_cur)
                S_R1Y:   nxt = S_CLR1;
                S_CLR1:  nxt = (PED && m_last) ? S_PEDG : S_R2G;
                S_R2G:   nxt = S_R2Y;
                S_R2Y:   nxt = S_CLR2;
                S_PEDG:  nxt = S_PEDY;
                S_PEDY:  nxt = S_CLR2;
                default: nxt = S_R1G;
            endcase
        end
        m_ack = (nxt == S_PEDG) && (m_cur != S_PEDG);
        if (PED && p) m_pend = 1'b1;
        if (m_ack)    m_pend = 1'b0;
        m_t   = (nxt != m_cur) ? 0 : m_t + 1;
        m_cur = nxt;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance model with the same inputs, compare.
    task automatic tick(input bit c, input bit p, input bit r);
        car_req = c; ped_req = p; rst_n = r;
        @(posedge clk);
        model_step(c, p, r);
        #1;
        cyc = r ? cyc + 1 : 0;
        check("model", {phase, R1G, R1Y, R1R, R2G, R2Y, R2R, FG, FY, FR, ped_ack},
              {1'b0, 1'b0, 1'b0, m_cur, lamps_of(m_cur), PED & m_ack});
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check("reset_vals", {phase, R1G, R1Y, R1R, R2G, R2Y, R2R, FG, FY, FR, ped_ack},
              {3'b000, S_R1G, 9'b100_001_001, 1'b0});
    endtask

    initial begin
        bit c;
        // ---- reset, then idle: road 1 green throughout
        do_reset();
        repeat (40) begin
            tick(1'b0, 1'b0, 1'b1);
            check("idle_r1g", {13'd0, R1G, R2R, FR}, 16'h0007);
        end

        // ---- car held from cycle 5
        do_reset();
        repeat (45) begin
            tick(cyc >= 5, 1'b0, 1'b1);
            if (cyc == 19) check("car_r1g_last", {13'd0, phase}, {13'd0, S_R1G});
            if (cyc == 20) check("car_r1y",      {13'd0, phase}, {13'd0, S_R1Y});
            if (cyc == 23) check("car_clr1",     {13'd0, phase}, {13'd0, S_CLR1});
            if (cyc == 24) check("car_r2g",      {13'd0, phase}, {13'd0, S_R2G});
            if (cyc == 34) check("car_r2y",      {13'd0, phase}, {13'd0, S_R2Y});
            if (cyc == 37) check("car_clr2",     {13'd0, phase}, {13'd0, S_CLR2});
            if (cyc == 38) check("car_back_r1g", {13'd0, phase}, {13'd0, S_R1G});
        end

        // ---- single button press at cycle 2
        do_reset();
        repeat (40) begin
            tick(1'b0, cyc == 2, 1'b1);
`ifdef TL_PED_EN
            if (cyc == 23) check("ped_pre_ack",  {12'd0, phase, ped_ack}, {12'd0, S_CLR1, 1'b0});
            if (cyc == 24) check("ped_ack",      {12'd0, phase, ped_ack}, {12'd0, S_PEDG, 1'b1});
            if (cyc == 25) check("ped_ack_once", {12'd0, phase, ped_ack}, {12'd0, S_PEDG, 1'b0});
            if (cyc == 32) check("ped_fy",       {13'd0, FG, FY, FR}, 16'h0002);
            if (cyc == 35) check("ped_clr2",     {13'd0, phase}, {13'd0, S_CLR2});
`else
            check("noped_hold", {12'd0, phase, ped_ack}, {12'd0, S_R1G, 1'b0});
`endif
        end

        // ---- car held and button held: cross phases alternate
        do_reset();
        repeat (110) begin
            tick(1'b1, 1'b1, 1'b1);
            if (cyc == 24) check("tie_first_r2", {13'd0, phase}, {13'd0, S_R2G});
`ifdef TL_PED_EN
            if (cyc == 62) check("tie_then_ped", {13'd0, phase}, {13'd0, S_PEDG});
            if (cyc == 98) check("tie_then_r2",  {13'd0, phase}, {13'd0, S_R2G});
`else
            if (cyc == 62) check("tie_noped_r2", {13'd0, phase}, {13'd0, S_R2G});
`endif
        end

        // ---- reset in the middle of road-2 green, then car held again
        do_reset();
        repeat (27) tick(1'b1, 1'b0, 1'b1);
        check("pre_rst_r2g", {13'd0, phase}, {13'd0, S_R2G});
        tick(1'b1, 1'b0, 1'b0);
        check("midrst_first_edge", {phase, R1G, R1Y, R1R, R2G, R2Y, R2R, FG, FY, FR, ped_ack},
              {3'b000, S_R1G, 9'b100_001_001, 1'b0});
        tick(1'b1, 1'b0, 1'b0);
        repeat (25) begin
            tick(1'b1, 1'b0, 1'b1);
            if (cyc == 19) check("rst_min_green", {13'd0, phase}, {13'd0, S_R1G});
            if (cyc == 20) check("rst_r1y",       {13'd0, phase}, {13'd0, S_R1Y});
        end

        // ---- randomized traffic with occasional reset
        c = 1'b0;
        repeat (3000) begin
            if ($urandom_range(0, 7) == 0) c = ~c;
            tick(c, $urandom_range(0, 15) == 0, $urandom_range(0, 299) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
